// File: rtl/lsu_mem_stage_pkg.sv
// rtl/lsu_mem_stage_pkg.sv - shared LSU types, width codes and load extraction helper
package lsu_mem_stage_pkg;

  localparam logic [1:0] DATA_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] DATA_WIDTH_HALF = 2'b01;
  localparam logic [1:0] DATA_WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_t;

  // Width code 11 falls through to the word case.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  width,
                                               input logic        sign_ext);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = rdata >> {offset, 3'b000};
    case (width)
      DATA_WIDTH_BYTE: result = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      DATA_WIDTH_HALF: result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:         result = shifted;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// rtl/lsu_mem_stage_align.sv - store data replication and byte-enable generation
module lsu_mem_stage_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [31:0] store_data,
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  output logic [31:0] wdata,
  output logic [3:0]  byte_en
);

  always_comb begin
    wdata   = store_data;
    byte_en = 4'b1111;
    case (width)
      DATA_WIDTH_BYTE: begin
        wdata   = {4{store_data[7:0]}};
        byte_en = 4'b0001 << addr_lo;
      end
      DATA_WIDTH_HALF: begin
        wdata   = {2{store_data[15:0]}};
        byte_en = 4'b0011 << addr_lo;
      end
      default: begin
        wdata   = store_data;
        byte_en = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - RV32E memory stage: single-outstanding data bus access and load formatting
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        invalid_MEM,
  input  logic        mem_access_MEM,
  input  logic        lsu_we_MEM,
  input  logic        lsu_sign_extend_MEM,
  input  logic [1:0]  data_width_MEM,
  input  logic [31:0] address_MEM,
  input  logic [31:0] store_data_MEM,
  output logic [31:0] load_data_MEM,
  output logic        stall_lsu,
  output logic        misaligned_MEM,
  output logic        lsu_done_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_en,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  lsu_state_t  state, state_next;
  logic [31:0] addr_q;
  logic [1:0]  width_q;
  logic        sext_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] load_q;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic        access_ok;
  logic        align_err;

  lsu_mem_stage_align u_align (
    .store_data (store_data_MEM),
    .width      (data_width_MEM),
    .addr_lo    (address_MEM[1:0]),
    .wdata      (fmt_wdata),
    .byte_en    (fmt_be)
  );

  always_comb begin
    case (data_width_MEM)
      DATA_WIDTH_BYTE: align_err = 1'b0;
      DATA_WIDTH_HALF: align_err = address_MEM[0];
      default:         align_err = |address_MEM[1:0];
    endcase
  end

  // Only a live memory instruction can raise a misalignment trap.
  assign misaligned_MEM = mem_access_MEM & ~invalid_MEM & align_err;
  assign access_ok      = mem_access_MEM & ~invalid_MEM & ~align_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LSU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE: if (access_ok) state_next = LSU_REQ;
      LSU_REQ:  if (dmem_gnt)  state_next = we_q ? LSU_DONE : LSU_WAIT;
      LSU_WAIT: if (dmem_rvalid) state_next = LSU_DONE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  // Payload is captured once in IDLE so the bus sees it stable until grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      width_q <= DATA_WIDTH_BYTE;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (state == LSU_IDLE && access_ok) begin
      addr_q  <= address_MEM;
      width_q <= data_width_MEM;
      sext_q  <= lsu_sign_extend_MEM;
      we_q    <= lsu_we_MEM;
      wdata_q <= fmt_wdata;
      be_q    <= fmt_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q <= '0;
    end else if (state == LSU_WAIT && dmem_rvalid) begin
      load_q <= load_extract(dmem_rdata, addr_q[1:0], width_q, sext_q);
    end
  end

  assign load_data_MEM = load_q;
  assign dmem_req      = (state == LSU_REQ);
  assign dmem_we       = dmem_req & we_q;
  assign dmem_addr     = {addr_q[31:2], 2'b00};
  assign dmem_wdata    = wdata_q;
  assign dmem_byte_en  = be_q;
  assign lsu_done_MEM  = (state == LSU_DONE);
  assign stall_lsu     = ((state == LSU_IDLE) & access_ok)
                       | (state == LSU_REQ) | (state == LSU_WAIT);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        invalid_MEM = 1'b0;
  logic        mem_access_MEM = 1'b0;
  logic        lsu_we_MEM = 1'b0;
  logic        lsu_sign_extend_MEM = 1'b0;
  logic [1:0]  data_width_MEM = 2'b00;
  logic [31:0] address_MEM = '0;
  logic [31:0] store_data_MEM = '0;
  logic [31:0] load_data_MEM;
  logic        stall_lsu;
  logic        misaligned_MEM;
  logic        lsu_done_MEM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_en;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int done_snap;

  lsu_mem_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .invalid_MEM         (invalid_MEM),
    .mem_access_MEM      (mem_access_MEM),
    .lsu_we_MEM          (lsu_we_MEM),
    .lsu_sign_extend_MEM (lsu_sign_extend_MEM),
    .data_width_MEM      (data_width_MEM),
    .address_MEM         (address_MEM),
    .store_data_MEM      (store_data_MEM),
    .load_data_MEM       (load_data_MEM),
    .stall_lsu           (stall_lsu),
    .misaligned_MEM      (misaligned_MEM),
    .lsu_done_MEM        (lsu_done_MEM),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_byte_en        (dmem_byte_en),
    .dmem_gnt            (dmem_gnt),
    .dmem_rvalid         (dmem_rvalid),
    .dmem_rdata          (dmem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && lsu_done_MEM) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] width,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata, input logic [3:0] exp_be);
    mem_access_MEM = 1'b1; lsu_we_MEM = 1'b1; data_width_MEM = width;
    address_MEM = addr; store_data_MEM = data;
    #1;
    chk("st_idle_stall", 32'(stall_lsu), 32'd1);
    chk("st_idle_req", 32'(dmem_req), 32'd0);
    step();
    mem_access_MEM = 1'b0; dmem_gnt = 1'b1;
    #1;
    chk("st_req", 32'(dmem_req), 32'd1);
    chk("st_we", 32'(dmem_we), 32'd1);
    chk("st_addr", dmem_addr, exp_addr);
    chk("st_wdata", dmem_wdata, exp_wdata);
    chk("st_be", 32'(dmem_byte_en), 32'(exp_be));
    chk("st_req_stall", 32'(stall_lsu), 32'd1);
    step();
    dmem_gnt = 1'b0;
    #1;
    chk("st_done", 32'(lsu_done_MEM), 32'd1);
    chk("st_done_stall", 32'(stall_lsu), 32'd0);
    chk("st_done_req", 32'(dmem_req), 32'd0);
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [1:0] width, input logic sext,
                          input logic [31:0] rdata, input logic [31:0] exp_addr, input logic [31:0] exp_data);
    mem_access_MEM = 1'b1; lsu_we_MEM = 1'b0; data_width_MEM = width;
    lsu_sign_extend_MEM = sext; address_MEM = addr;
    #1;
    chk("ld_idle_stall", 32'(stall_lsu), 32'd1);
    step();
    mem_access_MEM = 1'b0; dmem_gnt = 1'b1;
    #1;
    chk("ld_req", 32'(dmem_req), 32'd1);
    chk("ld_we", 32'(dmem_we), 32'd0);
    chk("ld_addr", dmem_addr, exp_addr);
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    #1;
    chk("ld_wait_stall", 32'(stall_lsu), 32'd1);
    chk("ld_wait_req", 32'(dmem_req), 32'd0);
    step();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    #1;
    chk("ld_done", 32'(lsu_done_MEM), 32'd1);
    chk("ld_done_stall", 32'(stall_lsu), 32'd0);
    chk("ld_data", load_data_MEM, exp_data);
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_lsu), 32'd0);
    chk("rst_done", 32'(lsu_done_MEM), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_be", 32'(dmem_byte_en), 32'd0);
    chk("rst_ld", load_data_MEM, 32'd0);
    rst = 1'b0;
    step();

    // Store byte to the top lane
    run_store(32'h0000_1003, 32'h0000_00AB, 2'b00, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
    step();
    chk("st_idle_after", 32'(lsu_done_MEM), 32'd0);

    // Load half from upper lane, signed then unsigned
    run_load(32'h0000_2002, 2'b01, 1'b1, 32'h8001_1234, 32'h0000_2000, 32'hFFFF_8001);
    step();
    run_load(32'h0000_2002, 2'b01, 1'b0, 32'h8001_1234, 32'h0000_2000, 32'h0000_8001);
    step();
    run_load(32'h0000_2001, 2'b00, 1'b1, 32'h0000_F000, 32'h0000_2000, 32'hFFFF_FFF0);
    step();

    // Misaligned word and half: no bus, no stall, load data kept
    mem_access_MEM = 1'b1; lsu_we_MEM = 1'b0; data_width_MEM = 2'b10; address_MEM = 32'h0000_3001;
    #1;
    chk("mis_word_flag", 32'(misaligned_MEM), 32'd1);
    chk("mis_word_stall", 32'(stall_lsu), 32'd0);
    step();
    chk("mis_word_req", 32'(dmem_req), 32'd0);
    chk("mis_word_ld", load_data_MEM, 32'hFFFF_FFF0);
    data_width_MEM = 2'b01; address_MEM = 32'h0000_3003;
    #1;
    chk("mis_half_flag", 32'(misaligned_MEM), 32'd1);
    step();
    chk("mis_half_req", 32'(dmem_req), 32'd0);
    data_width_MEM = 2'b01; address_MEM = 32'h0000_3002;
    #1;
    chk("aligned_half_flag", 32'(misaligned_MEM), 32'd0);
    mem_access_MEM = 1'b0;
    #1;
    chk("no_access_stall", 32'(stall_lsu), 32'd0);
    step();

    // Grant held off three cycles; inputs churn and invalid toggles meanwhile
    mem_access_MEM = 1'b1; lsu_we_MEM = 1'b1; data_width_MEM = 2'b01;
    address_MEM = 32'h0000_4002; store_data_MEM = 32'h1234_5678;
    step();
    for (int i = 0; i < 3; i++) begin
      invalid_MEM = ~invalid_MEM; address_MEM = 32'h0000_9999; store_data_MEM = 32'hFFFF_FFFF;
      #1;
      chk("gw_req", 32'(dmem_req), 32'd1);
      chk("gw_addr", dmem_addr, 32'h0000_4000);
      chk("gw_wdata", dmem_wdata, 32'h5678_5678);
      chk("gw_be", 32'(dmem_byte_en), 32'h0000_000C);
      chk("gw_stall", 32'(stall_lsu), 32'd1);
      step();
    end
    mem_access_MEM = 1'b0; invalid_MEM = 1'b0; dmem_gnt = 1'b1;
    #1;
    chk("gw_req_at_gnt", 32'(dmem_req), 32'd1);
    step();
    dmem_gnt = 1'b0;
    #1;
    chk("gw_done", 32'(lsu_done_MEM), 32'd1);
    step();

    // Reset while waiting for rvalid
    mem_access_MEM = 1'b1; lsu_we_MEM = 1'b0; data_width_MEM = 2'b10; address_MEM = 32'h0000_5000;
    step();
    mem_access_MEM = 1'b0; dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #1;
    chk("rw_in_wait", 32'(stall_lsu), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_req", 32'(dmem_req), 32'd0);
    chk("rw_stall", 32'(stall_lsu), 32'd0);
    chk("rw_ld", load_data_MEM, 32'd0);
    step();
    rst = 1'b0;
    step();
    run_load(32'h0000_5004, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0000_5004, 32'hDEAD_BEEF);
    step();

    // Back-to-back load then store
    done_snap = done_cnt;
    run_load(32'h0000_6003, 2'b00, 1'b0, 32'h7F00_0000, 32'h0000_6000, 32'h0000_007F);
    step();
    run_store(32'h0000_6008, 32'hCAFE_F00D, 2'b10, 32'h0000_6008, 32'hCAFE_F00D, 4'b1111);
    step();
    step();
    chk("b2b_done_pulses", 32'(done_cnt - done_snap), 32'd2);
    chk("b2b_ld_kept", load_data_MEM, 32'h0000_007F);
    chk("b2b_idle_req", 32'(dmem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
